// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: runs one full-adder slice LSB-first over WIDTH cycles.
// Optional subtract mode (a - b) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] psum_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic             s_d;
  logic             c_d;
  logic [WIDTH-1:0] psum_d;
  logic [WIDTH-1:0] b_load;
  logic             cin_load;

  // Two half adders chained through the carry flip-flop.
  always_comb begin
    s_d    = a_q[0] ^ b_q[0] ^ carry_q;
    c_d    = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & carry_q);
    psum_d = {s_d, psum_q[WIDTH-1:1]};
  end

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction as a + ~b + 1.
  assign b_load   = sub ? ~b : b;
  assign cin_load = sub;
`else
  assign b_load   = b;
  assign cin_load = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b_load;
            carry_q <= cin_load;
            cnt_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          psum_q  <= psum_d;
          carry_q <= c_d;
          a_q     <= {1'b0, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            sum_q   <= psum_d;
            cout_q  <= c_d;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus randomized operations
// checked against arithmetic a+b (or a-b in subtract builds).
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_cmp;
  int n_bad;

  logic [W-1:0] prev_sum;
  logic         prev_cout;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation at the current negedge and check every cycle until IDLE.
  task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic sb, input bit garble);
    logic [W-1:0] bx;
    logic [W:0]   r;
    bx = sb ? ~bb : bb;
    r  = {1'b0, aa} + {1'b0, bx} + {{W{1'b0}}, sb};
    a = aa;
    b = bb;
`ifdef SERIAL_ADD_SUB_EN
    sub = sb;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j <= W + 1; j++) begin
      n_cmp++;
      if (busy !== (j < W)) begin
        n_bad++;
        $display("FAIL op_busy j=%0d a=%h b=%h: got %b want %b", j, aa, bb, busy, (j < W));
      end
      n_cmp++;
      if (done !== (j == W)) begin
        n_bad++;
        $display("FAIL op_done j=%0d a=%h b=%h: got %b want %b", j, aa, bb, done, (j == W));
      end
      n_cmp++;
      if (j < W) begin
        if ({cout, sum} !== {prev_cout, prev_sum}) begin
          n_bad++;
          $display("FAIL op_hold j=%0d: got %b_%h want %b_%h", j, cout, sum, prev_cout, prev_sum);
        end
      end else begin
        if ({cout, sum} !== r) begin
          n_bad++;
          $display("FAIL op_result a=%h b=%h sub=%b: got %b_%h want %b_%h",
                   aa, bb, sb, cout, sum, r[W], r[W-1:0]);
        end
      end
      if (j < W + 1) begin
        if (garble) begin
          start = 1'($urandom_range(0, 1));
          a     = W'($urandom);
          b     = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
          sub   = 1'($urandom_range(0, 1));
`endif
        end
        @(negedge clk);
      end
    end
    start     = 1'b0;
    prev_sum  = r[W-1:0];
    prev_cout = r[W];
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, cout, sum} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got busy=%b done=%b cout=%b sum=%h want all 0", busy, done, cout, sum);
    end
    rst       = 1'b0;
    prev_sum  = '0;
    prev_cout = 1'b0;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, cout, sum} !== '0) begin
        n_bad++;
        $display("FAIL idle c=%0d: got busy=%b done=%b cout=%b sum=%h want all 0", c, busy, done, cout, sum);
      end
    end
  endtask

  task automatic test_directed();
    run_op(8'h00, 8'h00, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    a     = 8'h10;
    b     = 8'h20;
    start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 29) start = 1'b0;
      if (c == 3)  a = 8'h7F;
      if (c == 7)  a = 8'h10;
      n_cmp++;
      if (done !== ((c % 10) == 8)) begin
        n_bad++;
        $display("FAIL b2b_done c=%0d: got %b want %b", c, done, ((c % 10) == 8));
      end
      if ((c % 10) == 8) begin
        n_cmp++;
        if ({cout, sum} !== {1'b0, 8'h30}) begin
          n_bad++;
          $display("FAIL b2b_sum c=%0d: got %b_%h want 0_30", c, cout, sum);
        end
      end
    end
    prev_sum  = 8'h30;
    prev_cout = 1'b0;
  endtask

  task automatic test_async_reset();
    a     = 8'h0F;
    b     = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, cout, sum} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got busy=%b done=%b cout=%b sum=%h want all 0", busy, done, cout, sum);
    end
    @(negedge clk);
    rst       = 1'b0;
    prev_sum  = '0;
    prev_cout = 1'b0;
    repeat (12) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, cout, sum} !== '0) begin
        n_bad++;
        $display("FAIL post_reset_quiet: got busy=%b done=%b cout=%b sum=%h want all 0", busy, done, cout, sum);
      end
    end
    run_op(8'h03, 8'h04, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      run_op(W'($urandom), W'($urandom), 1'b0, bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    run_op(8'h05, 8'h07, 1'b1, 1'b0);
    run_op(8'h07, 8'h05, 1'b1, 1'b0);
    run_op(8'h07, 8'h05, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++)
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_idle();
    test_directed();
    test_back_to_back();
    test_async_reset();
    test_random();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
